// File: rtl/spi_master.sv
// Mode-0 SPI master that exchanges MSB-first bytes. SCLK is derived from CLK by a half-period divider.
// A byte is exchanged on each start. SS can stay low between bytes to form a multi-byte burst.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] data_to_send,
  input  logic       hold_ss,
  input  logic       release_ss,
  output logic       busy,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SCLK_HI, S_SCLK_LO, S_LAG, S_HOLD, S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    tx_shift_q;   // bits still to send after the one currently on MOSI
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          hold_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          ss_q;
  logic          busy_q;
  logic          dv_q;

  wire cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      hold_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HOLD: begin
          // A start request wins over release_ss when both are present in HOLD.
          if (start) begin
            tx_shift_q <= data_to_send[6:0];
            mosi_q     <= data_to_send[7];
            hold_q     <= hold_ss;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            ss_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_LEAD;
          end else if (state_q == S_HOLD && release_ss) begin
            cnt_q   <= '0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_LEAD, S_SCLK_LO: begin
          if (cnt_done) begin
            cnt_q      <= '0;
            sclk_q     <= 1'b1;
            rx_shift_q <= {rx_shift_q[6:0], MISO};
            state_q    <= S_SCLK_HI;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SCLK_HI: begin
          if (cnt_done) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_LAG;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              mosi_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[5:0], 1'b0};
              state_q    <= S_SCLK_LO;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_LAG: begin
          if (cnt_done) begin
            cnt_q     <= '0;
            rx_data_q <= rx_shift_q;
            dv_q      <= 1'b1;
            mosi_q    <= 1'b0;
            if (hold_q) begin
              busy_q  <= 1'b0;
              state_q <= S_HOLD;
            end else begin
              ss_q    <= 1'b1;
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          // Keeps SS high for a full half-period before another byte can start.
          if (cnt_done) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign received_data = rx_data_q;
  assign data_valid    = dv_q;
  assign SCLK          = sclk_q;
  assign MOSI          = mosi_q;
  assign SS            = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master. One instance runs with CLK_DIV=4 and a second with CLK_DIV=1.
// A small mode-0 slave model and a waveform monitor produce the expected values.
module tb_spi_master;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET;

  logic       start_a, hold_a, rel_a, miso_a;
  logic [7:0] din_a, rx_a;
  logic       busy_a, dv_a, sclk_a, mosi_a, ss_a;
  logic       miso_mode;

  logic       start_b, hold_b, rel_b;
  logic [7:0] din_b, rx_b;
  logic       busy_b, dv_b, sclk_b, mosi_b, ss_b;

  logic [7:0] s_tx = 8'h00, s_rx = 8'h00, s_byte;
  logic       s_sclk_p = 1'b0;

  assign miso_a = miso_mode ? s_tx[7] : mosi_a;

  spi_master #(.CLK_DIV(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .data_to_send(din_a),
    .hold_ss(hold_a), .release_ss(rel_a), .busy(busy_a), .received_data(rx_a),
    .data_valid(dv_a), .SCLK(sclk_a), .MOSI(mosi_a), .MISO(miso_a), .SS(ss_a)
  );

  spi_master #(.CLK_DIV(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .data_to_send(din_b),
    .hold_ss(hold_b), .release_ss(rel_b), .busy(busy_b), .received_data(rx_b),
    .data_valid(dv_b), .SCLK(sclk_b), .MOSI(mosi_b), .MISO(mosi_b), .SS(ss_b)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Mode-0 slave: shifts out on SCLK falling and captures MOSI on SCLK rising.
  always @(negedge CLK) begin
    if (ss_a) s_tx <= s_byte;
    else if (s_sclk_p && !sclk_a) s_tx <= {s_tx[6:0], 1'b0};
    if (!ss_a && !s_sclk_p && sclk_a) s_rx <= {s_rx[6:0], mosi_a};
    s_sclk_p <= sclk_a;
  end

  // Waveform monitor for the CLK_DIV=4 instance.
  int   pulses = 0, ss_low = 0, dv_n = 0, ss_rises = 0, run_bad = 0, mosi_bad = 0, run = 0;
  int   dv_cyc = 0, ss_rise_cyc = 0, busy_fall_cyc = 0;
  logic sclk_p = 1'b0, ss_p = 1'b1, busy_p = 1'b0, mosi_p = 1'b0, fell = 1'b0;

  always @(negedge CLK) begin
    if (!ss_a) ss_low <= ss_low + 1;
    if (dv_a) begin
      dv_n   <= dv_n + 1;
      dv_cyc <= cyc;
    end
    if (ss_a && !ss_p) begin
      ss_rises    <= ss_rises + 1;
      ss_rise_cyc <= cyc;
    end
    if (!busy_a && busy_p) busy_fall_cyc <= cyc;
    if (sclk_a && sclk_p && (mosi_a != mosi_p)) mosi_bad <= mosi_bad + 1;
    if (sclk_a != sclk_p) begin
      if (sclk_p && run != 4) run_bad <= run_bad + 1;
      else if (!sclk_p && fell && run != 4) run_bad <= run_bad + 1;
      if (sclk_a) pulses <= pulses + 1;
      run <= 1;
    end else begin
      run <= run + 1;
    end
    fell   <= ss_a ? 1'b0 : (fell | (sclk_p & ~sclk_a));
    sclk_p <= sclk_a;
    ss_p   <= ss_a;
    busy_p <= busy_a;
    mosi_p <= mosi_a;
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic h, output int t);
    start_a = 1'b1;
    din_a   = d;
    hold_a  = h;
    t       = cyc;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int max);
    int i = 0;
    while (!(!busy_a && ss_a) && i < max) begin
      tick();
      i++;
    end
    check("reach_idle", {30'd0, busy_a, ss_a}, 32'd1);
  endtask

  task automatic wait_hold_a(input int max);
    int i = 0;
    while (!(!busy_a && !ss_a) && i < max) begin
      tick();
      i++;
    end
    check("reach_hold", {30'd0, busy_a, ss_a}, 32'd0);
  endtask

  initial begin
    int t, p0, r0, l0, d0, s0, n, k, lat, dvb_n;
    logic prev;
    logic [16:0] vec;

    RESET = 1'b1;
    start_a = 1'b0; hold_a = 1'b0; rel_a = 1'b0; din_a = 8'h00;
    start_b = 1'b0; hold_b = 1'b0; rel_b = 1'b0; din_b = 8'h00;
    miso_mode = 1'b0;
    s_byte = 8'h3C;
    repeat (3) tick();
    check("rst_ss", ss_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_dv", dv_a, 0);
    check("rst_rx", rx_a, 8'h00);
    RESET = 1'b0;
    repeat (2) tick();

    // Loopback single byte
    p0 = pulses; r0 = run_bad; l0 = ss_low; d0 = dv_n;
    send_a(8'hA5, 1'b0, t);
    wait_idle_a(300);
    tick();
    check("a5_pulses", pulses - p0, 8);
    check("a5_phase_len", run_bad - r0, 0);
    check("a5_ss_low", ss_low - l0, 68);
    check("a5_dv_count", dv_n - d0, 1);
    check("a5_rx", rx_a, 8'hA5);
    check("a5_dv_latency", dv_cyc - t, 69);
    check("a5_ss_rise_eq_dv", ss_rise_cyc - dv_cyc, 0);
    check("a5_busy_after_ss", busy_fall_cyc - ss_rise_cyc, 4);

    // Slave model exchange
    miso_mode = 1'b1;
    tick();
    send_a(8'hC3, 1'b0, t);
    wait_idle_a(300);
    tick();
    check("slave_rx", s_rx, 8'hC3);
    check("master_rx", rx_a, 8'h3C);
    check("mosi_stable_hi", mosi_bad, 0);
    miso_mode = 1'b0;
    tick();

    // Burst of two bytes
    d0 = dv_n; s0 = ss_rises;
    send_a(8'h11, 1'b1, t);
    wait_hold_a(300);
    tick();
    check("burst_rx1", rx_a, 8'h11);
    check("burst_dv1", dv_n - d0, 1);
    check("burst_hold_ss", ss_a, 0);
    send_a(8'h22, 1'b0, t);
    check("burst_ss_low", ss_a, 0);
    check("burst_busy", busy_a, 1);
    wait_idle_a(300);
    tick();
    check("burst_rx2", rx_a, 8'h22);
    check("burst_dv2", dv_n - d0, 2);
    check("burst_ss_rises", ss_rises - s0, 1);
    check("burst_ss_at_dv", ss_rise_cyc - dv_cyc, 0);

    // HOLD then release_ss
    send_a(8'h5A, 1'b1, t);
    wait_hold_a(300);
    check("rel_rx", rx_a, 8'h5A);
    rel_a = 1'b1;
    tick();
    rel_a = 1'b0;
    check("rel_ss", ss_a, 1);
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      tick();
    end
    check("rel_busy_len", n, 4);
    check("rel_ss_idle", ss_a, 1);

    // HOLD with start and release together
    send_a(8'h3E, 1'b1, t);
    wait_hold_a(300);
    s0 = ss_rises;
    start_a = 1'b1; rel_a = 1'b1; din_a = 8'h77; hold_a = 1'b0;
    tick();
    start_a = 1'b0; rel_a = 1'b0;
    check("both_ss", ss_a, 0);
    check("both_busy", busy_a, 1);
    wait_idle_a(300);
    tick();
    check("both_rx", rx_a, 8'h77);
    check("both_ss_rises", ss_rises - s0, 1);

    // start held high throughout a transfer
    d0 = dv_n;
    start_a = 1'b1; din_a = 8'h96; hold_a = 1'b0;
    tick();
    din_a = 8'hFF;
    n = 0;
    while (busy_a && n < 300) begin
      tick();
      n++;
    end
    start_a = 1'b0;
    repeat (20) tick();
    check("spam_dv", dv_n - d0, 1);
    check("spam_rx", rx_a, 8'h96);
    check("spam_idle", {30'd0, busy_a, ss_a}, 32'd1);

    // Reset after the third SCLK pulse
    send_a(8'hF0, 1'b0, t);
    k = 0; n = 0; prev = 1'b0;
    while (!(k == 3 && !sclk_a) && n < 200) begin
      if (sclk_a && !prev) k++;
      prev = sclk_a;
      tick();
      n++;
    end
    check("abort_pulses", k, 3);
    RESET = 1'b1;
    d0 = dv_n;
    tick();
    check("abort_ss", ss_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_mosi", mosi_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_dv", dv_a, 0);
    check("abort_rx", rx_a, 8'h00);
    RESET = 1'b0;
    repeat (150) tick();
    check("abort_no_dv", dv_n - d0, 0);

    // CLK_DIV=1 loopback
    start_b = 1'b1; din_b = 8'h80; hold_b = 1'b0;
    t = cyc;
    tick();
    start_b = 1'b0;
    vec = '0; lat = 0; dvb_n = 0;
    for (int j = 1; j <= 25; j++) begin
      if (j <= 17) vec[j-1] = sclk_b;
      if (dv_b) begin
        dvb_n++;
        if (lat == 0) lat = cyc - t;
      end
      tick();
    end
    check("div1_sclk_seq", vec, 17'h0AAAA);
    check("div1_rx", rx_b, 8'h80);
    check("div1_dv_latency", lat, 18);
    check("div1_dv_count", dvb_n, 1);
    check("div1_idle", {30'd0, busy_b, ss_b}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
